frame_controller: RTL and testbench

- Per-frame sequencer for the renderer. It sits between the top-level start/increment_frame inputs and the geometry engine / rasterizer.
- On each frame request it runs three steps in order:
  - hardware-clears the frame buffer (to CLEAR_COLOR) and the Z-buffer (to Z_FAR) through a dedicated write port;
  - launches the geometry engine;
  - tracks the rasterizer busy window, with a timeout, and reports frame completion.
- It owns the animation frame index that the geometry engine uses to select vertex data.

---
 rtl/render_pkg.sv | 26 ++
 rtl/rise_edge_detect.sv | 33 +++
 rtl/frame_controller.sv | 176 +++++++++++++++++
 tb/tb_frame_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared renderer constants and types
//
// Holds the screen geometry, frame/Z buffer widths, the Z-buffer far value,
// the buffer address type and the frame sequencer state encoding.
// Port summary: none (package).
`timescale 1ns/1ps
package render_pkg;
    localparam int SCREEN_W   = 320;
    localparam int SCREEN_H   = 240;
    localparam int NUM_PIXELS = SCREEN_W * SCREEN_H;
    localparam int FB_ADDR_W  = 17;
    localparam int FB_PIXEL_W = 12;
    localparam int ZB_W       = 8;
    localparam logic [ZB_W-1:0] Z_FAR = 8'hFF;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_LAUNCH    = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_DONE      = 3'd5
    } frame_state_t;
endpackage

// File: rtl/rise_edge_detect.sv
// rtl/rise_edge_detect.sv - single-cycle rising-edge strobe for a level input
//
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset
//   i_level in   level input
//   o_rise  out  high for the cycle in which i_level is 1 and was 0 last cycle
`timescale 1ns/1ps
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_rise
);
    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = i_level;
    end

    // Reset loads the live level so an input held high through reset
    // does not look like a fresh edge afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= i_level;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign o_rise = i_level & ~prev_q;
endmodule

// File: rtl/frame_controller.sv
// rtl/frame_controller.sv - per-frame sequencer: buffer clear, geometry launch, raster wait
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_start             frame request level (rising edge starts a frame)
//   i_increment_frame   level (rising edge advances the animation index in IDLE)
//   i_rast_busy         rasterizer busy
//   o_geom_start        one-cycle geometry launch pulse
//   o_frame_idx         animation frame index
//   o_mem_sel           1 = clear port owns the FB/ZB write ports
//   o_clr_addr          clear write address
//   o_clr_fb_we/data    frame buffer clear write
//   o_clr_zb_we/data    Z-buffer clear write
//   o_busy              high outside IDLE
//   o_frame_done        one-cycle pulse at successful frame end
//   o_timeout           sticky timeout flag, cleared by rst or the next start
`timescale 1ns/1ps
module frame_controller
    import render_pkg::*;
#(
    parameter int              NUM_PIXELS      = render_pkg::NUM_PIXELS,
    parameter int              ADDR_W          = FB_ADDR_W,
    parameter int              FB_W            = FB_PIXEL_W,
    parameter int              ZB_W            = render_pkg::ZB_W,
    parameter logic [FB_W-1:0] CLEAR_COLOR     = '0,
    parameter logic [ZB_W-1:0] Z_FAR           = render_pkg::Z_FAR,
    parameter int              NUM_ANIM_FRAMES = 16,
    parameter int              TIMEOUT_CYCLES  = 50000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_start,
    input  logic                               i_increment_frame,
    input  logic                               i_rast_busy,
    output logic                               o_geom_start,
    output logic [$clog2(NUM_ANIM_FRAMES)-1:0] o_frame_idx,
    output logic                               o_mem_sel,
    output logic [ADDR_W-1:0]                  o_clr_addr,
    output logic                               o_clr_fb_we,
    output logic [FB_W-1:0]                    o_clr_fb_data,
    output logic                               o_clr_zb_we,
    output logic [ZB_W-1:0]                    o_clr_zb_data,
    output logic                               o_busy,
    output logic                               o_frame_done,
    output logic                               o_timeout
);
    localparam int IDX_W = $clog2(NUM_ANIM_FRAMES);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_ANIM_FRAMES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    frame_state_t      state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              timeout_q, timeout_d;
    logic              geom_start_q, geom_start_d;
    logic              clr_active_q, clr_active_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start_rise;
    logic              inc_rise;

    rise_edge_detect u_start_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (i_start),
        .o_rise  (start_rise)
    );

    rise_edge_detect u_inc_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (i_increment_frame),
        .o_rise  (inc_rise)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        tmo_d     = tmo_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                // Increment is applied even when start rises in the same
                // cycle, so the new frame renders with the advanced index.
                if (inc_rise) begin
                    idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                end
                if (start_rise) begin
                    state_d   = ST_CLEAR;
                    addr_d    = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_LAUNCH;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_LAUNCH: begin
                tmo_d   = '0;
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_WAIT_IDLE: begin
                // One counter spans both wait states, measured from launch.
                if (tmo_q != TMO_LAST) begin
                    tmo_d = tmo_q + 1'b1;
                end
                if ((state_q == ST_WAIT_BUSY) && i_rast_busy) begin
                    state_d = ST_WAIT_IDLE;
                end else if ((state_q == ST_WAIT_IDLE) && !i_rast_busy) begin
                    state_d = ST_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The launch pulse is registered from the LAUNCH state itself, so it
        // lands one cycle after the sweep ends; the other flags track state_d
        // and therefore coincide with the state they describe.
        geom_start_d = (state_q == ST_LAUNCH);
        clr_active_d = (state_d == ST_CLEAR);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            addr_q       <= '0;
            tmo_q        <= '0;
            timeout_q    <= 1'b0;
            geom_start_q <= 1'b0;
            clr_active_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
            tmo_q        <= tmo_d;
            timeout_q    <= timeout_d;
            geom_start_q <= geom_start_d;
            clr_active_q <= clr_active_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_geom_start  = geom_start_q;
    assign o_frame_idx   = idx_q;
    assign o_mem_sel     = clr_active_q;
    assign o_clr_addr    = addr_q;
    assign o_clr_fb_we   = clr_active_q;
    assign o_clr_fb_data = CLEAR_COLOR;
    assign o_clr_zb_we   = clr_active_q;
    assign o_clr_zb_data = Z_FAR;
    assign o_busy        = busy_q;
    assign o_frame_done  = done_q;
    assign o_timeout     = timeout_q;
endmodule

// File: tb/tb_frame_controller.sv
// tb/tb_frame_controller.sv - scoreboard bench for frame_controller
`timescale 1ns/1ps
module tb_frame_controller;
    import render_pkg::*;

    localparam int NPIX       = 1500;
    localparam int TMO        = 2000;
    localparam int NFR        = 16;
    localparam int AW         = 17;
    localparam int RAST_DELAY = 20;
    localparam int RAST_LEN   = 1000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic          i_inc = 1'b0;
    logic          i_rast_busy = 1'b0;
    logic          o_geom_start;
    logic [3:0]    o_frame_idx;
    logic          o_mem_sel;
    logic [AW-1:0] o_clr_addr;
    logic          o_clr_fb_we;
    logic [11:0]   o_clr_fb_data;
    logic          o_clr_zb_we;
    logic [7:0]    o_clr_zb_data;
    logic          o_busy;
    logic          o_frame_done;
    logic          o_timeout;

    frame_controller #(
        .NUM_PIXELS     (NPIX),
        .NUM_ANIM_FRAMES(NFR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_increment_frame(i_inc),
        .i_rast_busy      (i_rast_busy),
        .o_geom_start     (o_geom_start),
        .o_frame_idx      (o_frame_idx),
        .o_mem_sel        (o_mem_sel),
        .o_clr_addr       (o_clr_addr),
        .o_clr_fb_we      (o_clr_fb_we),
        .o_clr_fb_data    (o_clr_fb_data),
        .o_clr_zb_we      (o_clr_zb_we),
        .o_clr_zb_data    (o_clr_zb_data),
        .o_busy           (o_busy),
        .o_frame_done     (o_frame_done),
        .o_timeout        (o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint cyc;
        int     idx;
    } geom_exp_t;

    geom_exp_t     exp_geom_q[$];
    longint        exp_done_q[$];
    longint        exp_tmo_q[$];
    longint        exp_fall_q[$];

    int            n_vec = 0;
    int            n_err = 0;
    longint        cyc = 0;
    int            n_geom = 0;
    int            wr_count = 0;
    int            wr_err = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [11:0]   fb_mem[NPIX];
    logic [7:0]    zb_mem[NPIX];
    bit            rast_en = 1'b0;
    bit            busy_prev = 1'b0;
    bit            tmo_prev = 1'b0;
    int            cur_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_geom_start) begin
                n_geom++;
                check("geom_expected", longint'(exp_geom_q.size() != 0), 1);
                if (exp_geom_q.size() != 0) begin
                    geom_exp_t g;
                    g = exp_geom_q.pop_front();
                    check("geom_cycle", cyc, g.cyc);
                    check("geom_frame_idx", longint'(o_frame_idx), longint'(g.idx));
                end
            end
            if (o_frame_done) begin
                check("done_expected", longint'(exp_done_q.size() != 0), 1);
                if (exp_done_q.size() != 0) check("done_cycle", cyc, exp_done_q.pop_front());
            end
            if (o_timeout && !tmo_prev) begin
                check("timeout_expected", longint'(exp_tmo_q.size() != 0), 1);
                if (exp_tmo_q.size() != 0) check("timeout_cycle", cyc, exp_tmo_q.pop_front());
            end
            if (!o_busy && busy_prev) begin
                check("busy_fall_expected", longint'(exp_fall_q.size() != 0), 1);
                if (exp_fall_q.size() != 0) check("busy_fall_cycle", cyc, exp_fall_q.pop_front());
            end
            if (o_clr_fb_we) begin
                if (!o_clr_zb_we || !o_mem_sel || o_clr_addr != exp_addr ||
                    o_clr_addr >= AW'(NPIX)) begin
                    wr_err++;
                end else begin
                    fb_mem[o_clr_addr] = o_clr_fb_data;
                    zb_mem[o_clr_addr] = o_clr_zb_data;
                end
                exp_addr = exp_addr + 1'b1;
                wr_count++;
            end else if (o_clr_zb_we || o_mem_sel) begin
                wr_err++;
            end
        end
        busy_prev = o_busy;
        tmo_prev  = o_timeout;
    end

    // Rasterizer model: busy RAST_DELAY cycles after launch for RAST_LEN cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (o_geom_start && rast_en && !rst) begin
                repeat (RAST_DELAY) @(negedge clk);
                i_rast_busy = 1'b1;
                repeat (RAST_LEN) @(negedge clk);
                i_rast_busy = 1'b0;
                exp_done_q.push_back(cyc + 1);
                exp_fall_q.push_back(cyc + 2);
            end
        end
    end

    task automatic check_reset_values();
        check("rst_frame_idx", longint'(o_frame_idx), 0);
        check("rst_clr_addr", longint'(o_clr_addr), 0);
        check("rst_mem_sel", longint'(o_mem_sel), 0);
        check("rst_fb_we", longint'(o_clr_fb_we), 0);
        check("rst_zb_we", longint'(o_clr_zb_we), 0);
        check("rst_geom_start", longint'(o_geom_start), 0);
        check("rst_busy", longint'(o_busy), 0);
        check("rst_frame_done", longint'(o_frame_done), 0);
        check("rst_timeout", longint'(o_timeout), 0);
        check("rst_state_idle", longint'(dut.state_q == ST_IDLE), 1);
    endtask

    task automatic run_frame(input bit with_inc, input bit rast_on,
                             input bit inc_in_clear, input bit start_in_wait);
        longint s;
        int     g0;
        int     bad;
        int     waited;
        for (int i = 0; i < NPIX; i++) begin
            fb_mem[i] = 12'hABC;
            zb_mem[i] = 8'h5A;
        end
        wr_count = 0;
        wr_err   = 0;
        exp_addr = '0;
        if (with_inc) cur_idx = (cur_idx + 1) % NFR;
        rast_en = rast_on;
        g0 = n_geom;
        @(negedge clk);
        s = cyc + 1;
        exp_geom_q.push_back('{s + NPIX + 1, cur_idx});
        if (!rast_on) begin
            exp_tmo_q.push_back(s + NPIX + 1 + TMO);
            exp_fall_q.push_back(s + NPIX + 1 + TMO);
        end
        i_start = 1'b1;
        i_inc   = with_inc;
        wait_cycles(4);
        i_start = 1'b0;
        i_inc   = 1'b0;
        check("start_clears_timeout", longint'(o_timeout), 0);
        check("clear_owns_mem", longint'(o_mem_sel), 1);
        if (inc_in_clear) begin
            wait_cycles(10);
            i_inc = 1'b1;
            wait_cycles(3);
            i_inc = 1'b0;
        end
        waited = 0;
        while (n_geom == g0 && waited < NPIX + 100) begin
            @(negedge clk);
            waited++;
        end
        check("geom_seen", longint'(n_geom - g0), 1);
        check("clear_write_cycles", longint'(wr_count), NPIX);
        check("clear_write_errors", longint'(wr_err), 0);
        bad = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (fb_mem[i] !== 12'h000 || zb_mem[i] !== 8'hFF) bad++;
        end
        check("mem_cleared_bad_entries", longint'(bad), 0);
        if (start_in_wait) begin
            waited = 0;
            while (!i_rast_busy && waited < 100) begin
                @(negedge clk);
                waited++;
            end
            wait_cycles(100);
            i_start = 1'b1;
            wait_cycles(4);
            i_start = 1'b0;
        end
        waited = 0;
        while (o_busy && waited < TMO + RAST_LEN) begin
            @(negedge clk);
            waited++;
        end
        wait_cycles(5);
        check("idle_after_frame", longint'(o_busy), 0);
        check("state_idle_after_frame", longint'(dut.state_q == ST_IDLE), 1);
        check("timeout_flag", longint'(o_timeout), longint'(!rast_on));
        check("no_second_sweep", longint'(wr_count), NPIX);
        check("pending_geom", longint'(exp_geom_q.size()), 0);
        check("pending_done", longint'(exp_done_q.size()), 0);
        check("pending_timeout", longint'(exp_tmo_q.size()), 0);
        check("pending_busy_fall", longint'(exp_fall_q.size()), 0);
    endtask

    initial begin
        int waited;
        rst = 1'b1;
        wait_cycles(3);
        check_reset_values();
        check("clr_fb_data", longint'(o_clr_fb_data), 0);
        check("clr_zb_data", longint'(o_clr_zb_data), 255);
        rst = 1'b0;
        wait_cycles(2);

        // 17 increments from 0 wrap to 1.
        for (int k = 0; k < 17; k++) begin
            i_inc = 1'b1;
            wait_cycles(2);
            i_inc = 1'b0;
            wait_cycles(2);
        end
        check("idx_after_17_incs", longint'(o_frame_idx), 1);
        cur_idx = 1;

        run_frame(1'b0, 1'b1, 1'b0, 1'b0);   // normal frame
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);   // rasterizer never busy -> timeout
        run_frame(1'b0, 1'b1, 1'b1, 1'b0);   // clears timeout; inc during CLEAR ignored
        run_frame(1'b0, 1'b1, 1'b0, 1'b1);   // start during WAIT_IDLE ignored
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);   // start and inc together -> idx 2
        check("idx_after_joint_inc", longint'(o_frame_idx), 2);

        // Abort a sweep with reset at address 1000.
        rast_en = 1'b0;
        @(negedge clk);
        i_start = 1'b1;
        wait_cycles(4);
        i_start = 1'b0;
        waited = 0;
        while (o_clr_addr != AW'(1000) && waited < NPIX) begin
            @(negedge clk);
            waited++;
        end
        check("abort_addr_reached", longint'(o_clr_addr), 1000);
        rst = 1'b1;
        i_start = 1'b1;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        cur_idx = 0;
        wait_cycles(5);
        check("no_edge_from_held_start", longint'(o_busy), 0);
        i_start = 1'b0;
        wait_cycles(2);
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);   // fresh sweep from address 0

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(600000);
        $display("FAIL watchdog: simulation did not finish, vectors %0d", n_vec);
        $fatal(1);
    end
endmodule
